// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading-zero / leading-one counter with valid/ready handshake.
// Optional LZC_NORM_EN adds out_norm, the original operand left-shifted by the count.
module lzc_pipe #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all
`ifdef LZC_NORM_EN
  ,
  output logic [WIDTH-1:0] out_norm
`endif
);

  localparam int unsigned NG = WIDTH / 8;

  if (WIDTH < 8 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("lzc_pipe: WIDTH must be a power of two in 8..128");
  end

  // Leading-zero count of one byte, 8 when the byte is zero.
  function automatic logic [3:0] byte_lzc(input logic [7:0] b);
    logic [3:0] n;
    logic       hit;
    n   = 4'd8;
    hit = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (b[i] && !hit) begin
        n   = 4'(7 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  logic                 en;
  logic [WIDTH-1:0]     inv_c;
  logic [NG-1:0]        s1_nz_d, s1_nz_q;
  logic [NG-1:0][3:0]   s1_bc_d, s1_bc_q;
  logic                 s1_valid_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 all_d, all_q;
  logic                 out_valid_q;
  logic                 found;
`ifdef LZC_NORM_EN
  logic [WIDTH-1:0]     s1_data_q;
  logic [WIDTH-1:0]     norm_d, norm_q;
`endif

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Counting leading ones is counting leading zeros of the inverted operand.
  assign inv_c = in_mode ? ~in_data : in_data;

  // Stage 1: per-byte nonzero flag and byte count; group 0 is the most significant byte.
  always_comb begin
    s1_nz_d = '0;
    s1_bc_d = '0;
    for (int g = 0; g < int'(NG); g++) begin
      s1_nz_d[g] = |inv_c[WIDTH-1-8*g -: 8];
      s1_bc_d[g] = byte_lzc(inv_c[WIDTH-1-8*g -: 8]);
    end
  end

  // Stage 2: first nonzero group from the MSB side picks the count.
  always_comb begin
    cnt_d = CW'(WIDTH);
    all_d = 1'b1;
    found = 1'b0;
    for (int g = 0; g < int'(NG); g++) begin
      if (s1_nz_q[g] && !found) begin
        cnt_d = CW'(8 * g) + CW'(s1_bc_q[g]);
        all_d = 1'b0;
        found = 1'b1;
      end
    end
  end

`ifdef LZC_NORM_EN
  // A count of WIDTH shifts everything out, so an all-digit operand normalises to zero.
  assign norm_d = s1_data_q << cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      all_q       <= 1'b0;
`ifdef LZC_NORM_EN
      norm_q      <= '0;
`endif
    end else if (en) begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        cnt_q  <= cnt_d;
        all_q  <= all_d;
`ifdef LZC_NORM_EN
        norm_q <= norm_d;
`endif
      end
    end
  end

  // Stage-1 payload needs no reset; it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_nz_q   <= s1_nz_d;
      s1_bc_q   <= s1_bc_d;
`ifdef LZC_NORM_EN
      s1_data_q <= in_data;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = cnt_q;
  assign out_all   = all_q;
`ifdef LZC_NORM_EN
  assign out_norm  = norm_q;
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// Self-checking bench for lzc_pipe: directed table, random scoreboard, reset flush, width sweep.
// Build with +define+LZC_NORM_EN to also check out_norm.
module tb_lzc_pipe;

  typedef struct packed {
    logic [6:0]  count;
    logic        all;
    logic [63:0] norm;
  } res_t;

  typedef struct {
    logic [63:0] data;
    logic        mode;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_all;
  logic [63:0] in_data;
  logic [6:0]  out_count;
  logic [63:0] norm_s;

  logic         sw_valid, sw_mode, sw_ordy;
  logic [7:0]   d8;
  logic [31:0]  d32;
  logic [127:0] d128;
  logic         r8, r32, r128, v8, v32, v128, a8, a32, a128;
  logic [3:0]   c8;
  logic [5:0]   c32;
  logic [7:0]   c128;

  int total = 0;
  int bad   = 0;

  res_t exp_q[$];
  logic held = 1'b0;
  res_t held_r;

  always #5 clk = ~clk;

`ifdef LZC_NORM_EN
  logic [7:0]   n8;
  logic [31:0]  n32;
  logic [127:0] n128;
  lzc_pipe #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_all(out_all), .out_norm(norm_s));
  lzc_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8),
    .in_data(d8), .in_mode(sw_mode), .out_valid(v8), .out_ready(sw_ordy),
    .out_count(c8), .out_all(a8), .out_norm(n8));
  lzc_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r32),
    .in_data(d32), .in_mode(sw_mode), .out_valid(v32), .out_ready(sw_ordy),
    .out_count(c32), .out_all(a32), .out_norm(n32));
  lzc_pipe #(.WIDTH(128)) u128 (.clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r128),
    .in_data(d128), .in_mode(sw_mode), .out_valid(v128), .out_ready(sw_ordy),
    .out_count(c128), .out_all(a128), .out_norm(n128));
`else
  assign norm_s = '0;
  lzc_pipe #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_all(out_all));
  lzc_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8),
    .in_data(d8), .in_mode(sw_mode), .out_valid(v8), .out_ready(sw_ordy),
    .out_count(c8), .out_all(a8));
  lzc_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r32),
    .in_data(d32), .in_mode(sw_mode), .out_valid(v32), .out_ready(sw_ordy),
    .out_count(c32), .out_all(a32));
  lzc_pipe #(.WIDTH(128)) u128 (.clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r128),
    .in_data(d128), .in_mode(sw_mode), .out_valid(v128), .out_ready(sw_ordy),
    .out_count(c128), .out_all(a128));
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk bits from the MSB while they equal the counted digit.
  function automatic res_t model(input logic [63:0] d, input logic m);
    res_t r;
    int   c;
    logic stop;
    c    = 0;
    stop = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!stop && d[i] == m) c++;
      else stop = 1'b1;
    end
    r.count = 7'(c);
    r.all   = (c == 64);
    r.norm  = (c == 64) ? 64'd0 : (d << c);
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e);
    chk({tag, "_count"}, 128'(out_count), 128'(e.count));
    chk({tag, "_all"}, 128'(out_all), 128'(e.all));
`ifdef LZC_NORM_EN
    chk({tag, "_norm"}, 128'(norm_s), 128'(e.norm));
`endif
  endtask

  // One cycle on the main DUT: drive at negedge, score what transfers at the next posedge.
  task automatic step(input logic v, input logic [63:0] d, input logic m, input logic ordy,
                      input res_t e, output logic acc);
    res_t got;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
    chk("in_ready_eq_en", 128'(in_ready), 128'(!out_valid || out_ready));
    if (held) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      check_res("stall", held_r);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 128'(out_valid), 128'(0));
      end else begin
        got = exp_q.pop_front();
        check_res("result", got);
      end
    end
    held   = out_valid && !out_ready;
    held_r = '{count: out_count, all: out_all, norm: norm_s};
    acc    = in_valid && in_ready;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, 1'b1, '0, acc);
    step(1'b0, '0, 1'b0, 1'b1, '0, acc);
    chk("drain_left", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [64:0] rnd_beat();
    logic [63:0] d;
    logic        m;
    d = {$urandom, $urandom} >> $urandom_range(0, 64);
    m = 1'($urandom % 2);
    if (m) d = ~d;
    return {m, d};
  endfunction

  vec_t vecs[9];

  initial begin
    logic        acc;
    logic [64:0] b;
    int          n, cyc;

    vecs[0] = '{64'h0000_0000_0000_0001, 1'b0, '{7'd63, 1'b0, 64'h8000_0000_0000_0000}};
    vecs[1] = '{64'h0000_0000_0000_0000, 1'b0, '{7'd64, 1'b1, 64'h0}};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '{7'd64, 1'b1, 64'h0}};
    vecs[3] = '{64'hFFF0_0000_0000_0000, 1'b1, '{7'd12, 1'b0, 64'h0}};
    vecs[4] = '{64'hFFF0_0000_0000_0000, 1'b0, '{7'd0,  1'b0, 64'hFFF0_0000_0000_0000}};
    vecs[5] = '{64'h00FF_0000_0000_0000, 1'b0, '{7'd8,  1'b0, 64'hFF00_0000_0000_0000}};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, '{7'd0,  1'b0, 64'h7FFF_FFFF_FFFF_FFFF}};
    vecs[7] = '{64'h0000_0000_0001_0000, 1'b0, '{7'd47, 1'b0, 64'h8000_0000_0000_0000}};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, '{7'd63, 1'b0, 64'h0}};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    sw_valid = 1'b0; sw_mode = 1'b0; sw_ordy = 1'b1; d8 = '0; d32 = '0; d128 = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_count", 128'(out_count), 128'(0));
    chk("rst_all", 128'(out_all), 128'(0));
    chk("rst_norm", 128'(norm_s), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;

    // Directed table, back to back
    foreach (vecs[i]) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++)
        step(1'b1, vecs[i].data, vecs[i].mode, 1'b1, vecs[i].exp, acc);
    end
    drain();

    // 100 back-to-back random beats with a 5-cycle stall mid-stream
    n = 0; cyc = 0;
    b = rnd_beat();
    while (n < 100 && cyc < 1000) begin
      step(1'b1, b[63:0], b[64], !(cyc >= 40 && cyc < 45), model(b[63:0], b[64]), acc);
      if (acc) begin n++; b = rnd_beat(); end
      cyc++;
    end
    chk("stream_accepted", 128'(n), 128'(100));
    drain();

    // Random valid/ready patterns with bubbles
    for (int i = 0; i < 300; i++) begin
      b = rnd_beat();
      step(1'($urandom % 2), b[63:0], b[64], ($urandom % 4) != 0, model(b[63:0], b[64]), acc);
    end
    drain();

    // Two beats in flight, then a one-cycle reset while a beat is presented
    step(1'b1, 64'h0000_0000_00F0_0000, 1'b0, 1'b1, model(64'h0000_0000_00F0_0000, 1'b0), acc);
    step(1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, model(64'h0FFF_FFFF_FFFF_FFFF, 1'b1), acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h1; in_mode = 1'b0; out_ready = 1'b0;
    @(negedge clk); #1;
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    held = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, '0, acc);
      chk("flush_quiet", 128'(out_valid), 128'(0));
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0000_0100_0000_0000; in_mode = 1'b0; out_ready = 1'b1;
    #1 chk("post_rst_accept", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("post_rst_lat1", 128'(out_valid), 128'(0));
    @(negedge clk); #1;
    chk("post_rst_lat2", 128'(out_valid), 128'(1));
    check_res("post_rst", model(64'h0000_0100_0000_0000, 1'b0));
    @(negedge clk); #1;
    chk("post_rst_gone", 128'(out_valid), 128'(0));

    // Width sweep: one terminating bit at every position, both modes
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < 128; p++) begin
        @(negedge clk);
        sw_valid = 1'b1;
        sw_mode  = 1'(m);
        d8   = 8'(1) << (p % 8);
        d32  = 32'(1) << (p % 32);
        d128 = 128'(1) << p;
        if (m == 1) begin d8 = ~d8; d32 = ~d32; d128 = ~d128; end
        @(negedge clk);
        sw_valid = 1'b0;
        @(negedge clk); #1;
        chk("sweep8_valid", 128'(v8), 128'(1));
        chk("sweep8_count", 128'(c8), 128'(7 - (p % 8)));
        chk("sweep32_count", 128'(c32), 128'(31 - (p % 32)));
        chk("sweep128_count", 128'(c128), 128'(127 - p));
        chk("sweep128_all", 128'(a128), 128'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
